dualrail_and_env_driver: RTL

Synchronous environment stage wrapped around the dual-rail AND-gate Mealy MSFSM block.
- Upstream side: converts single-rail requests (two operand bits) into return-to-zero dual-rail codewords on a_P/a_M/b_P/b_M.
- Downstream side: consumes out_P/out_M, checks the result codeword and the spacer, then presents a single-rail response with an error code.
- One clock domain, shared with the MSFSM block; no synchronisers.

---
 rtl/dualrail_and_env_driver.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/dualrail_and_env_driver.sv
// rtl/dualrail_and_env_driver.sv - single-rail to dual-rail RTZ environment around the dual-rail AND MSFSM
module dualrail_and_env_driver #(
   parameter int TIMEOUT = 64,
   parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic       req_a,
   input  logic       req_b,
   output logic       a_P,
   output logic       a_M,
   output logic       b_P,
   output logic       b_M,
   input  logic       out_P,
   input  logic       out_M,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic       rsp_data,
   output logic [1:0] rsp_err
);

   typedef enum logic [1:0] {IDLE, EVAL, RTZ, RESP} state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

   localparam logic [1:0] ERR_OK       = 2'b00;
   localparam logic [1:0] ERR_VALUE    = 2'b01;
   localparam logic [1:0] ERR_CONFLICT = 2'b10;
   localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
   logic             op_a_q, op_a_d, op_b_q, op_b_d;
   logic             a_p_q, a_p_d, a_m_q, a_m_d, b_p_q, b_p_d, b_m_q, b_m_d;
   logic             req_ready_q, req_ready_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic             rsp_data_q, rsp_data_d;
   logic [1:0]       rsp_err_q, rsp_err_d;

   assign a_P       = a_p_q;
   assign a_M       = a_m_q;
   assign b_P       = b_p_q;
   assign b_M       = b_m_q;
   assign req_ready = req_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_err   = rsp_err_q;

   // wait counter that sticks at its terminal value instead of wrapping
   always_comb begin
      cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
   end

   // next-state and registered-output logic; rails drop to spacer whenever EVAL is left
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      op_a_d      = op_a_q;
      op_b_d      = op_b_q;
      a_p_d       = a_p_q;
      a_m_d       = a_m_q;
      b_p_d       = b_p_q;
      b_m_d       = b_m_q;
      req_ready_d = req_ready_q;
      rsp_valid_d = rsp_valid_q;
      rsp_data_d  = rsp_data_q;
      rsp_err_d   = rsp_err_q;
      case (state_q)
         IDLE: begin
            a_p_d       = 1'b0;
            a_m_d       = 1'b0;
            b_p_d       = 1'b0;
            b_m_d       = 1'b0;
            req_ready_d = 1'b1;
            if (req_valid && req_ready_q) begin
               op_a_d      = req_a;
               op_b_d      = req_b;
               a_p_d       = req_a;
               a_m_d       = ~req_a;
               b_p_d       = req_b;
               b_m_d       = ~req_b;
               req_ready_d = 1'b0;
               cnt_d       = '0;
               rsp_data_d  = 1'b0;
               rsp_err_d   = ERR_OK;
               state_d     = EVAL;
            end
         end
         EVAL: begin
            cnt_d = cnt_inc;
            if (out_P && out_M) begin
               rsp_err_d = ERR_CONFLICT;
               state_d   = RTZ;
            end else if (out_P ^ out_M) begin
               rsp_data_d = out_P;
               rsp_err_d  = (out_P == (op_a_q & op_b_q)) ? ERR_OK : ERR_VALUE;
               state_d    = RTZ;
            end else if (cnt_q == CNT_MAX) begin
               rsp_err_d = ERR_TIMEOUT;
               state_d   = RTZ;
            end
            if (state_d == RTZ) begin
               a_p_d = 1'b0;
               a_m_d = 1'b0;
               b_p_d = 1'b0;
               b_m_d = 1'b0;
               cnt_d = '0;
            end
         end
         RTZ: begin
            if (!out_P && !out_M) begin
               rsp_valid_d = 1'b1;
               state_d     = RESP;
            end else if (cnt_q == CNT_MAX) begin
               rsp_err_d   = ERR_TIMEOUT;
               rsp_valid_d = 1'b1;
               state_d     = RESP;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               req_ready_d = 1'b1;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // state and output registers with synchronous reset to an all-spacer idle
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         op_a_q      <= 1'b0;
         op_b_q      <= 1'b0;
         a_p_q       <= 1'b0;
         a_m_q       <= 1'b0;
         b_p_q       <= 1'b0;
         b_m_q       <= 1'b0;
         req_ready_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= 1'b0;
         rsp_err_q   <= ERR_OK;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         op_a_q      <= op_a_d;
         op_b_q      <= op_b_d;
         a_p_q       <= a_p_d;
         a_m_q       <= a_m_d;
         b_p_q       <= b_p_d;
         b_m_q       <= b_m_d;
         req_ready_q <= req_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

endmodule
